// File: rtl/mdr_pkg.sv
// Shared types and default sizing for the memory data register block.
package mdr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mdr_state_e;

   localparam int MDR_DATA_WIDTH  = 32;
   localparam int MDR_NUM_SRC     = 2;
   localparam int MDR_TIMEOUT_CYC = 16;

endpackage : mdr_pkg

// File: rtl/mdr_mem_if_mux.sv
// N-to-1 combinational word mux; an out-of-range select yields zero with valid_o low.
module mux_n_to_1 #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SRC    = 2,
   parameter int SEL_W      = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC*DATA_WIDTH-1:0] data_i,
   input  logic [SEL_W-1:0]              sel_i,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic                          valid_o
);

   always_comb begin
      data_o  = '0;
      valid_o = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (int'(sel_i) == k) begin
            data_o  = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            valid_o = 1'b1;
         end
      end
   end

endmodule : mux_n_to_1

// File: rtl/mdr_mem_if.sv
// Memory Data Register with registered N-way input mux and a req/ack memory read.
// Define MDR_TIMEOUT_EN to abort reads that see no mem_ack within TIMEOUT_CYC cycles.
module mdr_mem_if
   import mdr_pkg::*;
#(
   parameter int DATA_WIDTH  = MDR_DATA_WIDTH,
   parameter int NUM_SRC     = MDR_NUM_SRC,
   parameter int SEL_W       = $clog2(NUM_SRC),
   parameter int TIMEOUT_CYC = MDR_TIMEOUT_CYC
) (
   input  logic                          clock,
   input  logic                          clear,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_in,
   input  logic [SEL_W-1:0]              sel,
   input  logic                          MDRin,
   input  logic                          Read,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   input  logic                          mem_ack,
   output logic                          mem_req,
   output logic [DATA_WIDTH-1:0]         mdr_q,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
      $error("mdr_mem_if: NUM_SRC must be in 2..16");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("mdr_mem_if: TIMEOUT_CYC must be at least 1");
   end

   mdr_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  mem_req_q, mem_req_d;
   logic [DATA_WIDTH-1:0] mux_data;
   logic                  mux_valid;

   mux_n_to_1 #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_SRC    (NUM_SRC),
      .SEL_W      (SEL_W)
   ) u_mux (
      .data_i  (src_in),
      .sel_i   (sel),
      .data_o  (mux_data),
      .valid_o (mux_valid)
   );

`ifdef MDR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q   <= IDLE;
         data_q    <= '0;
         mem_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         mem_req_q <= mem_req_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      mem_req_d = mem_req_q;
`ifdef MDR_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            // Read wins over a simultaneous MDRin; the load is dropped.
            if (Read) begin
               state_d   = REQ;
               mem_req_d = 1'b1;
`ifdef MDR_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end else if (MDRin && mux_valid) begin
               data_d = mux_data;
            end
         end
         REQ: begin
            if (mem_ack) begin
               data_d    = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = DONE;
`ifdef MDR_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               // Last allowed REQ cycle passed without an ack.
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   assign mem_req = mem_req_q;
   assign mdr_q   = data_q;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);

endmodule : mdr_mem_if

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
- Memory Data Register with an integrated N-way registered input mux and a memory-read handshake; generalises the 2-to-1 BusMuxOut/Mdatain selection.
- Sits between the internal bus and the memory port.
- Loads from any of NUM_SRC data sources on MDRin, or runs a request/acknowledge read transaction on Read.
- Drives the captured word back toward the bus.

Parameters:
- DATA_WIDTH, 32, width of every data word and of the MDR.
- NUM_SRC, 2, number of mux sources; legal range 2..16.
- SEL_W, $clog2(NUM_SRC), width of sel.
- TIMEOUT_CYC, 16, cycles to wait for mem_ack before abort (used only with MDR_TIMEOUT_EN).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- clear  in  1  asynchronous, active-high reset.
- src_in  in  NUM_SRC*DATA_WIDTH  flattened sources; source k = bits [k*DATA_WIDTH +: DATA_WIDTH]; source 0 = BusMuxOut.
- sel  in  SEL_W  source select for MDRin loads.
- MDRin  in  1  load MDR from selected source.
- Read  in  1  start a memory read transaction.
- mem_rdata  in  DATA_WIDTH  memory read data, valid while mem_ack=1.
- mem_ack  in  1  memory acknowledge.
- mem_req  out  1  memory read request, registered.
- mdr_q  out  DATA_WIDTH  MDR contents.
- busy  out  1  high while a transaction is in progress (state != IDLE).
- done  out  1  one-cycle pulse after a successful memory capture.
- err  out  1  sticky timeout flag; constant 0 without MDR_TIMEOUT_EN.

Behaviour:
- Reset (clear=1, asynchronous): mdr_q=0, mem_req=0, done=0, err=0, state=IDLE, timeout counter=0. Clear mid-transaction aborts immediately. No capture occurs even if mem_ack is high.
- States: IDLE, REQ, DONE.
- IDLE:
  - Read=1 -> REQ, mem_req=1 on the next edge. Read has priority over MDRin; a simultaneous MDRin is dropped.
  - Else MDRin=1 with sel<NUM_SRC -> mdr_q <= selected source, 1-cycle latency.
  - MDRin with sel>=NUM_SRC -> mdr_q holds; no other effect.
- REQ:
  - mem_req held at 1.
  - mem_ack sampled high -> mdr_q <= mem_rdata, mem_req <= 0, -> DONE.
  - mem_ack may already be high on the first REQ cycle; capture then occurs at that edge (minimum 2 edges from Read to captured data).
  - MDRin and Read are ignored in REQ.
- DONE: done=1 for exactly one cycle, -> IDLE. MDRin and Read are ignored in DONE.
- busy = (state != IDLE), combinational from the state register.
- mdr_q changes only on a valid MDRin load, on a memory capture, or on clear.
- No arithmetic on data; widths pass through unchanged.

Optional Feature:
- Macro: MDR_TIMEOUT_EN.
- When defined:
  - Counter counts cycles spent in REQ.
  - If it reaches TIMEOUT_CYC without mem_ack: mem_req <= 0, err <= 1 (sticky until clear), -> IDLE, no done pulse, mdr_q unchanged.
  - mem_ack on the same edge the counter reaches TIMEOUT_CYC counts as success.
  - Counter resets on entry to REQ.
- When undefined: REQ waits indefinitely, err tied to 0, no counter logic.

Decomposition:
- Package mdr_pkg:
  - state enum (IDLE, REQ, DONE);
  - default DATA_WIDTH and NUM_SRC constants;
  - TIMEOUT_CYC default.
- Sub-module mux_n_to_1: combinational, parametrised DATA_WIDTH/NUM_SRC. Out-of-range select returns 0 and raises a valid=0 flag, which the parent uses to suppress the load.

Test Plan:
- Reset: clear=1 mid-REQ with mem_ack=1 -> mdr_q=0, mem_req=0, busy=0, done=0, err=0 immediately (asynchronous).
- Mux load: NUM_SRC=4, src k = 16*(k+1); sel=2, MDRin=1 -> mdr_q=48 one edge later.
- Mux load, out of range: NUM_SRC=3, sel=3, MDRin=1 -> mdr_q holds 48.
- Read, delayed ack: Read pulse, mem_ack rises 3 cycles after mem_req, mem_rdata=32'hDEADBEEF -> mdr_q=DEADBEEF on the ack edge, mem_req falls, done high exactly one cycle, busy low after DONE.
- Read + MDRin together: Read=1, MDRin=1, sel=0, BusMuxOut=16 in IDLE -> load dropped, transaction starts. MDRin pulses during REQ leave mdr_q unchanged until the ack capture.
- Timeout (MDR_TIMEOUT_EN, TIMEOUT_CYC=4): Read with mem_ack held 0 -> mem_req drops after 4 REQ cycles, err=1 and stays 1, no done, mdr_q unchanged. A subsequent successful read keeps err=1 until clear.
